// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode selector, width helper
// and the parameter legality predicate evaluated at elaboration.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned fifo_count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit fifo_is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit fifo_params_ok(input int unsigned width,
                                        input int unsigned depth,
                                        input int unsigned aempty_off,
                                        input int unsigned afull_off);
    return (width >= 1) && (depth >= 4) && fifo_is_pow2(depth) &&
           (aempty_off < depth) && (afull_off < depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset,
// so it maps onto block or distributed RAM.
module fifo_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     write_en,
  input  logic [$clog2(DEPTH)-1:0] write_addr,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     read_en,
  input  logic [$clog2(DEPTH)-1:0] read_addr,
  output logic [WIDTH-1:0]         read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (read_en) begin
      read_data <= mem[read_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-flags, registered error pulses
// and a selectable standard or first-word-fall-through read mode.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AEMPTY_OFF = 1,
  parameter int unsigned AFULL_OFF  = 1,
  parameter fifo_mode_e  MODE       = FIFO_STD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_req,
  input  logic [WIDTH-1:0]           write_data,
  input  logic                       read_req,
  output logic [WIDTH-1:0]           read_data,
  output logic                       empty,
  output logic                       full,
  output logic                       aempty,
  output logic                       afull,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = fifo_count_width(DEPTH);
  localparam logic [CW-1:0] FULL_LVL   = CW'(DEPTH);
  localparam logic [CW-1:0] AEMPTY_LVL = CW'(AEMPTY_OFF);
  localparam logic [CW-1:0] AFULL_LVL  = CW'(DEPTH - AFULL_OFF);
  localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);

  if (!fifo_params_ok(WIDTH, DEPTH, AEMPTY_OFF, AFULL_OFF)) begin : g_bad_params
    $error("sync_fifo: illegal WIDTH/DEPTH/AEMPTY_OFF/AFULL_OFF combination");
  end

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             write_acc;
  logic             read_acc;
  logic             ram_re;
  logic             ram_nonempty;
  logic             q_valid;
  logic [WIDTH-1:0] ram_q;

  assign write_acc    = write_req && !full;
  assign read_acc     = read_req && !empty;
  assign ram_nonempty = (wptr != rptr);

  // In FWFT the RAM's registered read port doubles as the output stage: it is
  // refilled whenever it holds nothing or is being popped and RAM has data.
  // rptr therefore tracks RAM reads, while count tracks user-visible pops.
  assign ram_re = (MODE == FIFO_FWFT) ? ((!q_valid || read_acc) && ram_nonempty)
                                      : read_acc;

  fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk       (clk),
    .write_en  (write_acc),
    .write_addr(wptr[AW-1:0]),
    .write_data(write_data),
    .read_en   (ram_re),
    .read_addr (rptr[AW-1:0]),
    .read_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      q_valid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_acc) begin
        wptr <= wptr + PTR_ONE;
      end
      if (ram_re) begin
        rptr <= rptr + PTR_ONE;
      end
      unique case ({write_acc, read_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= write_req && full;
      underflow <= read_req && empty;
      // STD: marks that read_data has been loaded since reset.
      // FWFT: the output stage holds the head word.
      if (MODE == FIFO_FWFT) begin
        if (ram_re) begin
          q_valid <= 1'b1;
        end else if (read_acc) begin
          q_valid <= 1'b0;
        end
      end else if (read_acc) begin
        q_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    full      = (count == FULL_LVL);
    empty     = (MODE == FIFO_FWFT) ? !q_valid : (count == '0);
    aempty    = (count <= AEMPTY_LVL);
    afull     = (count >= AFULL_LVL);
    read_data = q_valid ? ram_q : '0;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one STD and one FWFT instance share stimulus,
// expected values are hand-derived constants per step.
module tb_sync_fifo;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       write_req;
  logic [7:0] write_data;
  logic       read_req;

  logic [7:0] s_read_data, f_read_data;
  logic       s_empty, s_full, s_aempty, s_afull, s_overflow, s_underflow;
  logic       f_empty, f_full, f_aempty, f_afull, f_overflow, f_underflow;
  logic [4:0] s_count, f_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  sync_fifo #(
    .WIDTH(8), .DEPTH(16), .AEMPTY_OFF(2), .AFULL_OFF(2), .MODE(FIFO_STD)
  ) dut_std (
    .clk(clk), .reset(reset), .write_req(write_req), .write_data(write_data),
    .read_req(read_req), .read_data(s_read_data), .empty(s_empty), .full(s_full),
    .aempty(s_aempty), .afull(s_afull), .count(s_count), .overflow(s_overflow),
    .underflow(s_underflow)
  );

  sync_fifo #(
    .WIDTH(8), .DEPTH(16), .AEMPTY_OFF(2), .AFULL_OFF(2), .MODE(FIFO_FWFT)
  ) dut_fwft (
    .clk(clk), .reset(reset), .write_req(write_req), .write_data(write_data),
    .read_req(read_req), .read_data(f_read_data), .empty(f_empty), .full(f_full),
    .aempty(f_aempty), .afull(f_afull), .count(f_count), .overflow(f_overflow),
    .underflow(f_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_req = 1'b0;
    read_req  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    write_data = '0;
    idle();
    step();
    step();
    reset = 1'b0;
    step();

    check("rst_empty",  s_empty,     1);
    check("rst_aempty", s_aempty,    1);
    check("rst_full",   s_full,      0);
    check("rst_afull",  s_afull,     0);
    check("rst_count",  s_count,     0);
    check("rst_rdata",  s_read_data, 0);
    check("rst_fempty", f_empty,     1);
    check("rst_fcount", f_count,     0);

    // STD fill 0x00..0x0F, flags checked after every write.
    for (int i = 0; i < 16; i++) begin
      write_req  = 1'b1;
      write_data = 8'(i);
      step();
      check("fill_count",  s_count,  i + 1);
      check("fill_empty",  s_empty,  0);
      check("fill_aempty", s_aempty, (i + 1 <= 2)  ? 1 : 0);
      check("fill_afull",  s_afull,  (i + 1 >= 14) ? 1 : 0);
      check("fill_full",   s_full,   (i + 1 == 16) ? 1 : 0);
      check("fill_ovf",    s_overflow, 0);
    end
    write_data = 8'hFF;
    step();
    check("ovf_pulse", s_overflow, 1);
    check("ovf_count", s_count,    16);
    idle();
    step();
    check("ovf_clear", s_overflow, 0);
    check("ovf_hold",  s_count,    16);

    // STD drain, data visible one cycle after its read edge.
    for (int i = 0; i < 16; i++) begin
      read_req = 1'b1;
      step();
      check("drain_data",  s_read_data, i);
      check("drain_count", s_count,     15 - i);
      check("drain_unf",   s_underflow, 0);
    end
    check("drain_empty", s_empty, 1);
    step();
    check("unf_pulse", s_underflow, 1);
    check("unf_hold",  s_read_data, 8'h0F);
    idle();
    step();
    check("unf_clear", s_underflow, 0);
    check("unf_data",  s_read_data, 8'h0F);

    // Wrap-around: preload 5 words, then 40 cycles of simultaneous read/write.
    for (int i = 0; i < 5; i++) begin
      write_req  = 1'b1;
      write_data = 8'(8'h40 + i);
      step();
    end
    check("wrap_pre", s_count, 5);
    read_req = 1'b1;
    for (int j = 0; j < 40; j++) begin
      write_data = 8'(8'h45 + j);
      step();
      check("wrap_data",  s_read_data, 8'h40 + j);
      check("wrap_count", s_count,     5);
      check("wrap_ovf",   s_overflow,  0);
      check("wrap_unf",   s_underflow, 0);
    end
    idle();

    // Full FIFO with simultaneous read and write: write dropped, read accepted.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      write_req  = 1'b1;
      write_data = 8'(8'h20 + i);
      step();
    end
    read_req   = 1'b1;
    write_data = 8'hEE;
    step();
    check("rw_full_ovf",   s_overflow,  1);
    check("rw_full_count", s_count,     15);
    check("rw_full_data",  s_read_data, 8'h20);
    write_req = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      check("rw_full_drain", s_read_data, 8'h20 + i);
    end
    check("rw_full_empty", s_empty, 1);
    idle();

    // FWFT single word: count after N, head word after N+1, pop at N+2.
    do_reset();
    step();
    write_req  = 1'b1;
    write_data = 8'hA5;
    step();
    idle();
    check("fw_n_count", f_count, 1);
    check("fw_n_empty", f_empty, 1);
    step();
    check("fw_n1_data",  f_read_data, 8'hA5);
    check("fw_n1_empty", f_empty,     0);
    check("fw_n1_count", f_count,     1);
    read_req = 1'b1;
    step();
    idle();
    check("fw_pop_empty", f_empty,     1);
    check("fw_pop_count", f_count,     0);
    check("fw_pop_unf",   f_underflow, 0);

    // FWFT back-to-back pops at one word per cycle.
    for (int i = 0; i < 3; i++) begin
      write_req  = 1'b1;
      write_data = 8'(8'h11 * (i + 1));
      step();
    end
    idle();
    step();
    check("fw_b2b_head", f_read_data, 8'h11);
    check("fw_b2b_cnt",  f_count,     3);
    read_req = 1'b1;
    step();
    check("fw_b2b_2", f_read_data, 8'h22);
    step();
    check("fw_b2b_3", f_read_data, 8'h33);
    check("fw_b2b_c", f_count,     1);
    step();
    idle();
    check("fw_b2b_empty", f_empty, 1);
    check("fw_b2b_zero",  f_count, 0);

    // Reset mid-stream with both requests high.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      write_req  = 1'b1;
      write_data = 8'(8'h90 + i);
      step();
    end
    check("mid_pre", s_count, 9);
    read_req   = 1'b1;
    write_data = 8'h77;
    reset      = 1'b1;
    step();
    reset = 1'b0;
    idle();
    check("mid_count", s_count,     0);
    check("mid_empty", s_empty,     1);
    check("mid_ovf",   s_overflow,  0);
    check("mid_unf",   s_underflow, 0);
    check("mid_rdata", s_read_data, 0);
    check("mid_fcnt",  f_count,     0);
    check("mid_fempt", f_empty,     1);
    write_req  = 1'b1;
    write_data = 8'h5A;
    step();
    idle();
    step();
    check("mid_fdata", f_read_data, 8'h5A);
    read_req = 1'b1;
    step();
    idle();
    check("mid_sdata", s_read_data, 8'h5A);
    check("mid_scnt",  s_count,     0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
